// File: rtl/bcd_cnt_pkg.sv
// Shared types, constants and helpers for the two-digit BCD modulo counter.
package bcd_cnt_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    // Decimal value of a two-digit BCD number. Computed in 8 bits so that
    // non-BCD digits cannot wrap into a plausible value before truncation.
    function automatic logic [6:0] bcd2val(input bcd_digit_t tens, input bcd_digit_t units);
        logic [7:0] v;
        v = {4'd0, tens} * 8'd10 + {4'd0, units};
        return v[6:0];
    endfunction

    // Inclusive range check of a decimal value.
    function automatic logic val_ok(input logic [6:0] v, input logic [6:0] lo,
                                    input logic [6:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD decade register with set/clear/inc/dec controls and wrap flags.
module bcd_digit
    import bcd_cnt_pkg::*;
#(
    parameter bcd_digit_t RstVal = BCD_MIN
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       set_i,
    input  bcd_digit_t set_val_i,
    input  logic       clr_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output bcd_digit_t digit_o,
    output logic       wrap9_o,
    output logic       wrap0_o
);

    bcd_digit_t digit_q, digit_d;

    // Next digit: set > clear > increment > decrement; wraps stay inside the decade.
    always_comb begin
        digit_d = digit_q;
        if (set_i) begin
            digit_d = set_val_i;
        end else if (clr_i) begin
            digit_d = BCD_MIN;
        end else if (inc_i) begin
            digit_d = (digit_q >= BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
        end else if (dec_i) begin
            digit_d = (digit_q == BCD_MIN || digit_q > BCD_MAX) ? BCD_MAX : digit_q - 4'd1;
        end
    end

    // Digit register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            digit_q <= RstVal;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;
    assign wrap9_o = (digit_q == BCD_MAX);
    assign wrap0_o = (digit_q == BCD_MIN);

endmodule

// File: rtl/bcd_mod_cnt.sv
// Two-digit BCD modulo counter MIN_VAL..MAX_VAL with up/down, range-checked
// load and combinational carry/borrow. Defining BCD_MOD_CNT_ADJ_EN adds the
// adj time-set input (step up without carry).
module bcd_mod_cnt
    import bcd_cnt_pkg::*;
#(
    parameter int unsigned MAX_VAL = 59,
    parameter int unsigned MIN_VAL = 0,
    parameter int unsigned RST_VAL = MIN_VAL
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       cnten,
    input  logic       updn,
    input  logic       load,
`ifdef BCD_MOD_CNT_ADJ_EN
    input  logic       adj,
`endif
    input  logic [3:0] ldup,
    input  logic [3:0] ldlow,
    output logic       ca,
    output logic       ld_err,
    output logic [3:0] digitup,
    output logic [3:0] digitlow
);

    localparam logic [6:0] MinV = 7'(MIN_VAL);
    localparam logic [6:0] MaxV = 7'(MAX_VAL);
    localparam bcd_digit_t MinTens = bcd_digit_t'(MIN_VAL / 10);
    localparam bcd_digit_t MinUnits = bcd_digit_t'(MIN_VAL % 10);
    localparam bcd_digit_t MaxTens = bcd_digit_t'(MAX_VAL / 10);
    localparam bcd_digit_t MaxUnits = bcd_digit_t'(MAX_VAL % 10);
    localparam bcd_digit_t RstTens = bcd_digit_t'(RST_VAL / 10);
    localparam bcd_digit_t RstUnits = bcd_digit_t'(RST_VAL % 10);

    logic adj_w;
`ifdef BCD_MOD_CNT_ADJ_EN
    assign adj_w = adj;
`else
    assign adj_w = 1'b0;
`endif

    bcd_digit_t tens, units;
    logic       u_wrap9, u_wrap0, t_wrap9, t_wrap0;
    logic [6:0] val, ld_val;
    logic       legal, ld_ok, step, step_up;
    logic       wr, u_inc, u_dec, t_inc, t_dec, ld_err_d, ld_err_q;
    bcd_digit_t tgt_tens, tgt_units;

    // Tens-digit wrap flags carry no information the range compare lacks.
    logic unused_tens_flags;
    assign unused_tens_flags = t_wrap9 ^ t_wrap0;

    assign val     = bcd2val(tens, units);
    assign legal   = (tens <= BCD_MAX) && (units <= BCD_MAX) && val_ok(val, MinV, MaxV);
    assign ld_val  = bcd2val(ldup, ldlow);
    assign ld_ok   = (ldup <= BCD_MAX) && (ldlow <= BCD_MAX) && val_ok(ld_val, MinV, MaxV);
    // adj steps upward regardless of updn and outranks cnten.
    assign step    = ~load & (adj_w | cnten);
    assign step_up = adj_w | updn;

    // Per-edge decision: load, then range wrap / illegal recovery, then digit ripple.
    always_comb begin
        wr        = 1'b0;
        tgt_tens  = tens;
        tgt_units = units;
        u_inc     = 1'b0;
        u_dec     = 1'b0;
        t_inc     = 1'b0;
        t_dec     = 1'b0;
        ld_err_d  = 1'b0;
        if (load) begin
            if (ld_ok) begin
                wr        = 1'b1;
                tgt_tens  = ldup;
                tgt_units = ldlow;
            end else begin
                ld_err_d = 1'b1;
            end
        end else if (step) begin
            if (!legal || (step_up && val == MaxV)) begin
                wr        = 1'b1;
                tgt_tens  = MinTens;
                tgt_units = MinUnits;
            end else if (!step_up && val == MinV) begin
                wr        = 1'b1;
                tgt_tens  = MaxTens;
                tgt_units = MaxUnits;
            end else if (step_up) begin
                u_inc = 1'b1;
                t_inc = u_wrap9;
            end else begin
                u_dec = 1'b1;
                t_dec = u_wrap0;
            end
        end
    end

    bcd_digit #(
        .RstVal (RstUnits)
    ) u_units (
        .clk_i     (CLK),
        .rst_i     (RST),
        .set_i     (wr && tgt_units != BCD_MIN),
        .set_val_i (tgt_units),
        .clr_i     (wr && tgt_units == BCD_MIN),
        .inc_i     (u_inc),
        .dec_i     (u_dec),
        .digit_o   (units),
        .wrap9_o   (u_wrap9),
        .wrap0_o   (u_wrap0)
    );

    bcd_digit #(
        .RstVal (RstTens)
    ) u_tens (
        .clk_i     (CLK),
        .rst_i     (RST),
        .set_i     (wr && tgt_tens != BCD_MIN),
        .set_val_i (tgt_tens),
        .clr_i     (wr && tgt_tens == BCD_MIN),
        .inc_i     (t_inc),
        .dec_i     (t_dec),
        .digit_o   (tens),
        .wrap9_o   (t_wrap9),
        .wrap0_o   (t_wrap0)
    );

    // Load-reject pulse: high only for the cycle after a rejected load.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ld_err_q <= 1'b0;
        end else begin
            ld_err_q <= ld_err_d;
        end
    end

    assign ca = cnten & ~load & ~adj_w & ((updn & (val == MaxV)) | (~updn & (val == MinV)));
    assign ld_err   = ld_err_q;
    assign digitup  = tens;
    assign digitlow = units;

endmodule

// File: tb/tb_bcd_mod_cnt.sv
// Self-checking bench for bcd_mod_cnt: three parameterisations (0..59, 1..12,
// 0..23) driven one at a time, with a reference model feeding a scoreboard.
module tb_bcd_mod_cnt;

    logic       CLK = 1'b0;
    logic       rst_s   [3];
    logic       cnten_s [3];
    logic       updn_s  [3];
    logic       load_s  [3];
    logic       adj_s   [3];
    logic [3:0] ldup_s  [3];
    logic [3:0] ldlow_s [3];
    logic       ca_s    [3];
    logic       err_s   [3];
    logic [3:0] dup_s   [3];
    logic [3:0] dlo_s   [3];

    int mn [3] = '{0, 1, 0};
    int mx [3] = '{59, 12, 23};
    int mv [3] = '{0, 0, 0};

    typedef struct {
        string      tag;
        logic [3:0] up;
        logic [3:0] lo;
        logic       err;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    bcd_mod_cnt u_d0 (
        .CLK (CLK), .RST (rst_s[0]), .cnten (cnten_s[0]), .updn (updn_s[0]),
        .load (load_s[0]),
`ifdef BCD_MOD_CNT_ADJ_EN
        .adj (adj_s[0]),
`endif
        .ldup (ldup_s[0]), .ldlow (ldlow_s[0]), .ca (ca_s[0]), .ld_err (err_s[0]),
        .digitup (dup_s[0]), .digitlow (dlo_s[0])
    );

    bcd_mod_cnt #(.MAX_VAL(12), .MIN_VAL(1)) u_d1 (
        .CLK (CLK), .RST (rst_s[1]), .cnten (cnten_s[1]), .updn (updn_s[1]),
        .load (load_s[1]),
`ifdef BCD_MOD_CNT_ADJ_EN
        .adj (adj_s[1]),
`endif
        .ldup (ldup_s[1]), .ldlow (ldlow_s[1]), .ca (ca_s[1]), .ld_err (err_s[1]),
        .digitup (dup_s[1]), .digitlow (dlo_s[1])
    );

    bcd_mod_cnt #(.MAX_VAL(23)) u_d2 (
        .CLK (CLK), .RST (rst_s[2]), .cnten (cnten_s[2]), .updn (updn_s[2]),
        .load (load_s[2]),
`ifdef BCD_MOD_CNT_ADJ_EN
        .adj (adj_s[2]),
`endif
        .ldup (ldup_s[2]), .ldlow (ldlow_s[2]), .ca (ca_s[2]), .ld_err (err_s[2]),
        .digitup (dup_s[2]), .digitlow (dlo_s[2])
    );

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            rst_s[i] = 1'b0; cnten_s[i] = 1'b0; updn_s[i] = 1'b0; load_s[i] = 1'b0;
            adj_s[i] = 1'b0; ldup_s[i] = 4'd0; ldlow_s[i] = 4'd0;
        end
    endtask

    // One clock cycle on instance d: drive, check ca before the edge, model the
    // edge into the scoreboard, then compare registered outputs after it.
    task automatic cyc(input int d, input bit r, input bit c, input bit u, input bit l,
                       input bit a, input logic [3:0] lt, input logic [3:0] lu,
                       input string tag);
        logic exp_ca;
        logic exp_err;
        exp_t e;
        exp_t got;
        idle_all();
        rst_s[d] = r; cnten_s[d] = c; updn_s[d] = u; load_s[d] = l; adj_s[d] = a;
        ldup_s[d] = lt; ldlow_s[d] = lu;
        exp_ca = c && !l && !a && ((u && mv[d] == mx[d]) || (!u && mv[d] == mn[d]));
        exp_err = 1'b0;
        if (r) begin
            mv[d] = mn[d];
        end else if (l) begin
            if (lt <= 9 && lu <= 9 && (lt * 10 + lu) >= mn[d] && (lt * 10 + lu) <= mx[d])
                mv[d] = lt * 10 + lu;
            else
                exp_err = 1'b1;
        end else if (a || c) begin
            if (a || u) mv[d] = (mv[d] == mx[d]) ? mn[d] : mv[d] + 1;
            else        mv[d] = (mv[d] == mn[d]) ? mx[d] : mv[d] - 1;
        end
        e.tag = tag;
        e.up  = 4'(mv[d] / 10);
        e.lo  = 4'(mv[d] % 10);
        e.err = exp_err;
        sb.push_back(e);
        #1;
        checks++;
        assert (ca_s[d] === exp_ca) else begin
            failures++;
            $error("FAIL %s ca: got %b expected %b", tag, ca_s[d], exp_ca);
        end
        @(posedge CLK);
        #1;
        got = sb.pop_front();
        checks++;
        assert ({dup_s[d], dlo_s[d], err_s[d]} === {got.up, got.lo, got.err}) else begin
            failures++;
            $error("FAIL %s digits/ld_err: got %h%h/%b expected %h%h/%b", got.tag,
                   dup_s[d], dlo_s[d], err_s[d], got.up, got.lo, got.err);
        end
    endtask

    initial begin
        idle_all();
        #2;
        cyc(0, 1, 0, 0, 0, 0, 4'd0, 4'd0, "rst_d0");
        cyc(1, 1, 0, 0, 0, 0, 4'd0, 4'd0, "rst_d1");
        cyc(2, 1, 0, 0, 0, 0, 4'd0, 4'd0, "rst_d2");

        // Full up-count lap 00..59..00 on the default range.
        for (int i = 0; i < 60; i++) cyc(0, 0, 1, 1, 0, 0, 4'd0, 4'd0, $sformatf("up%0d", i));

        // 1..12 range: wrap both ways.
        cyc(1, 0, 0, 0, 1, 0, 4'd1, 4'd2, "d1_ld12");
        cyc(1, 0, 1, 1, 0, 0, 4'd0, 4'd0, "d1_up_wrap");
        cyc(1, 0, 1, 0, 0, 0, 4'd0, 4'd0, "d1_dn_wrap");
        cyc(1, 0, 1, 0, 0, 0, 4'd0, 4'd0, "d1_dn_11");

        // 0..23 range: load acceptance and rejection.
        cyc(2, 0, 0, 0, 1, 0, 4'd2, 4'd3, "d2_ld23");
        cyc(2, 0, 0, 0, 1, 0, 4'd2, 4'd4, "d2_ld24_rej");
        cyc(2, 0, 0, 0, 0, 0, 4'd0, 4'd0, "d2_err_clear");
        cyc(2, 0, 0, 0, 1, 0, 4'd1, 4'hA, "d2_ld1A_rej");
        cyc(2, 0, 1, 1, 0, 0, 4'd0, 4'd0, "d2_up_wrap");

        // Load beats count.
        cyc(0, 0, 0, 0, 1, 0, 4'd5, 4'd9, "d0_ld59");
        cyc(0, 0, 1, 1, 1, 0, 4'd0, 4'd5, "d0_ld05_cnt");

        // Reset beats count; then up-step from 00 and down-wrap to 59.
        cyc(0, 0, 0, 0, 1, 0, 4'd3, 4'd7, "d0_ld37");
        cyc(0, 1, 1, 1, 0, 0, 4'd0, 4'd0, "d0_rst_cnt");
        cyc(0, 0, 1, 1, 0, 0, 4'd0, 4'd0, "d0_up_00");
        cyc(0, 0, 0, 0, 1, 0, 4'd0, 4'd0, "d0_ld00");
        cyc(0, 0, 1, 0, 0, 0, 4'd0, 4'd0, "d0_dn_wrap");

`ifdef BCD_MOD_CNT_ADJ_EN
        cyc(0, 0, 0, 0, 1, 0, 4'd5, 4'd9, "adj_ld59a");
        cyc(0, 0, 0, 0, 0, 1, 4'd0, 4'd0, "adj_wrap");
        cyc(0, 0, 0, 0, 1, 0, 4'd5, 4'd9, "adj_ld59b");
        cyc(0, 0, 1, 1, 0, 1, 4'd0, 4'd0, "adj_cnt_wrap");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
